bcd_stopwatch_timer: RTL and testbench

Parametrised stopwatch/countdown timer for the DE0-Nano-SoC baseline.
- Counts NUM_DIGITS BCD digits at TICK_HZ, up (stopwatch) or down from a preset (countdown).
- Handles start/stop, clear and lap-freeze push-buttons internally.
- Drives a multiplexed digit scan that feeds the existing 7-segment decoder on GPIO_1.

---
 rtl/bcd_stopwatch_timer.sv | 133 +++++++++++++
 tb/tb_bcd_stopwatch_timer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch_timer.sv
// bcd_stopwatch_timer: BCD stopwatch/countdown with release-edge keys, lap freeze and multiplexed digit scan
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (above position 0) on scan_digit.
module bcd_stopwatch_timer #(
    parameter int CLK_HZ     = 50000000,
    parameter int TICK_HZ    = 10,
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_HZ    = 1000
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic                    KEY_START_N,
    input  logic                    KEY_CLEAR_N,
    input  logic                    KEY_LAP_N,
    input  logic                    MODE_DOWN,
    input  logic [4*NUM_DIGITS-1:0] PRESET,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [3:0]              scan_digit,
    output logic [NUM_DIGITS-1:0]   scan_pos,
    output logic                    running,
    output logic                    lap_active,
    output logic                    done
);
    localparam int W        = 4 * NUM_DIGITS;
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int PW       = $clog2(TICK_DIV);
    localparam int SW       = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int IW       = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t        state, start_next;
    logic [2:0]    key_s1, key_s2, key_q, key_rel;
    logic [W-1:0]  count, snap, count_inc, count_dec, preset_clamped;
    logic [PW-1:0] pre;
    logic [SW-1:0] scan_cnt;
    logic [IW-1:0] scan_idx, scan_idx_next;
    logic [3:0]    scan_nibble;
    logic          mode_q, tick, carry, borrow, scan_wrap;

    // Keys idle high, so synchronizers reset to 1 to avoid a phantom release after reset
    assign key_rel    = key_s2 & ~key_q;
    assign tick       = state == RUN && pre == PW'(TICK_DIV - 1);
    assign digits_out = lap_active ? snap : count;
    assign scan_pos   = NUM_DIGITS'(1) << scan_idx;
    assign scan_wrap  = scan_cnt == SW'(SCAN_DIV - 1);

    always_comb begin
        count_inc      = count;
        count_dec      = count;
        preset_clamped = PRESET;
        carry          = 1'b1;
        borrow         = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            count_inc[4*i+:4]      = carry ? (count[4*i+:4] == 4'd9 ? 4'd0 : count[4*i+:4] + 4'd1) : count[4*i+:4];
            count_dec[4*i+:4]      = borrow ? (count[4*i+:4] == 4'd0 ? 4'd9 : count[4*i+:4] - 4'd1) : count[4*i+:4];
            preset_clamped[4*i+:4] = PRESET[4*i+:4] > 4'd9 ? 4'd9 : PRESET[4*i+:4];
            carry                  = carry & (count[4*i+:4] == 4'd9);
            borrow                 = borrow & (count[4*i+:4] == 4'd0);
        end
    end

    always_comb begin
        start_next = state == IDLE   ? ((mode_q && count == '0) ? IDLE : RUN) :
                     state == RUN    ? PAUSED :
                     state == PAUSED ? RUN : state;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            key_s1     <= '1;
            key_s2     <= '1;
            key_q      <= '1;
            state      <= IDLE;
            count      <= '0;
            snap       <= '0;
            pre        <= '0;
            mode_q     <= 1'b0;
            running    <= 1'b0;
            lap_active <= 1'b0;
            done       <= 1'b0;
        end else begin
            key_s1 <= {KEY_LAP_N, KEY_CLEAR_N, KEY_START_N};
            key_s2 <= key_s1;
            key_q  <= key_s2;
            if (key_rel[1]) begin
                state      <= IDLE;
                running    <= 1'b0;
                pre        <= '0;
                lap_active <= 1'b0;
                done       <= 1'b0;
                mode_q     <= MODE_DOWN;
                count      <= MODE_DOWN ? preset_clamped : '0;
            end else begin
                if (state == RUN) pre <= tick ? '0 : pre + 1'b1;
                if (tick) count <= mode_q ? count_dec : count_inc;
                if (tick && mode_q && count_dec == '0) begin
                    state      <= DONE;
                    running    <= 1'b0;
                    done       <= 1'b1;
                    lap_active <= 1'b0;
                end else if (key_rel[0]) begin
                    state   <= start_next;
                    running <= start_next == RUN;
                end else if (key_rel[2] && (state == RUN || state == PAUSED)) begin
                    lap_active <= ~lap_active;
                    if (!lap_active) snap <= count;
                end
            end
        end
    end

    always_comb begin
        scan_idx_next = scan_wrap ? (scan_idx == IW'(NUM_DIGITS - 1) ? '0 : scan_idx + 1'b1) : scan_idx;
        scan_nibble   = digits_out[4*scan_idx_next+:4];
`ifdef LEADING_ZERO_BLANK_EN
        if (scan_idx_next != '0 && (digits_out >> (4 * scan_idx_next)) == '0) scan_nibble = 4'hF;
`endif
    end

    // scan_digit is fetched for the index being entered so it lines up with scan_pos
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            scan_cnt   <= '0;
            scan_idx   <= '0;
            scan_digit <= '0;
        end else begin
            scan_cnt   <= scan_wrap ? '0 : scan_cnt + 1'b1;
            scan_idx   <= scan_idx_next;
            scan_digit <= scan_nibble;
        end
    end
endmodule

// File: tb/tb_bcd_stopwatch_timer.sv
// tb_bcd_stopwatch_timer: scoreboard bench with a decimal reference model of the stopwatch
// Honours LEADING_ZERO_BLANK_EN for the expected scan digits.
module tb_bcd_stopwatch_timer;
    localparam int CLK_HZ = 100, TICK_HZ = 10, SCAN_HZ = 50, ND = 4;
    localparam int TDIV = CLK_HZ / TICK_HZ, SDIV = CLK_HZ / SCAN_HZ;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic        CLOCK_50 = 1'b0, RESET_N = 1'b0;
    logic        KEY_START_N = 1'b1, KEY_CLEAR_N = 1'b1, KEY_LAP_N = 1'b1, MODE_DOWN = 1'b0;
    logic [15:0] PRESET = '0, digits_out;
    logic [3:0]  scan_digit;
    logic [3:0]  scan_pos;
    logic        running, lap_active, done;

    logic        W_START_N = 1'b1, W_CLEAR_N = 1'b1;
    logic [7:0]  w_digits;
    logic [3:0]  w_scan_digit;
    logic [1:0]  w_scan_pos;
    logic        w_running, w_lap, w_done;

    int checks = 0, errors = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    bcd_stopwatch_timer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NUM_DIGITS(ND), .SCAN_HZ(SCAN_HZ)) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .KEY_START_N(KEY_START_N), .KEY_CLEAR_N(KEY_CLEAR_N),
        .KEY_LAP_N(KEY_LAP_N), .MODE_DOWN(MODE_DOWN), .PRESET(PRESET), .digits_out(digits_out),
        .scan_digit(scan_digit), .scan_pos(scan_pos), .running(running), .lap_active(lap_active), .done(done)
    );

    // Small, fast instance so the all-9s wrap is reachable in a short run
    bcd_stopwatch_timer #(.CLK_HZ(100), .TICK_HZ(50), .NUM_DIGITS(2), .SCAN_HZ(50)) u_wrap (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .KEY_START_N(W_START_N), .KEY_CLEAR_N(W_CLEAR_N),
        .KEY_LAP_N(1'b1), .MODE_DOWN(1'b0), .PRESET(8'h00), .digits_out(w_digits),
        .scan_digit(w_scan_digit), .scan_pos(w_scan_pos), .running(w_running), .lap_active(w_lap), .done(w_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < ND; i++) begin
            r[4*i+:4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int preset_value(input logic [15:0] b);
        int r = 0, p = 1;
        for (int i = 0; i < ND; i++) begin
            r += (b[4*i+:4] > 9 ? 9 : int'(b[4*i+:4])) * p;
            p *= 10;
        end
        return r;
    endfunction

    // Reference model: decimal integers, advanced once per rising edge
    typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_DONE} mstate_t;
    mstate_t     m_state;
    int          m_count, m_snap, m_pre, m_edges, m_idx;
    bit          m_mode, m_lap, m_done;
    logic [3:0]  m_sd;
    bit [2:0]    h_s, h_c, h_l;
    logic [15:0] exp_q[$];
    int          pw10[5] = '{1, 10, 100, 1000, 10000};

    function automatic int m_disp();
        return m_lap ? m_snap : m_count;
    endfunction

    task automatic m_reset();
        m_state = M_IDLE; m_count = 0; m_snap = 0; m_pre = 0; m_edges = 0; m_idx = 0;
        m_mode = 0; m_lap = 0; m_done = 0; m_sd = 4'h0;
        h_s = '1; h_c = '1; h_l = '1;
        exp_q.delete();
    endtask

    task automatic m_step();
        bit fs, fc, fl, tick;
        int old, prev;
        fs = h_s[1] & ~h_s[2];
        fc = h_c[1] & ~h_c[2];
        fl = h_l[1] & ~h_l[2];
        h_s = {h_s[1:0], KEY_START_N};
        h_c = {h_c[1:0], KEY_CLEAR_N};
        h_l = {h_l[1:0], KEY_LAP_N};
        prev = m_disp();
        if (fc) begin
            m_state = M_IDLE; m_pre = 0; m_lap = 0; m_done = 0; m_mode = MODE_DOWN;
            m_count = MODE_DOWN ? preset_value(PRESET) : 0;
        end else begin
            tick = m_state == M_RUN && m_pre == TDIV - 1;
            if (m_state == M_RUN) m_pre = tick ? 0 : m_pre + 1;
            old = m_count;
            if (tick) m_count = m_mode ? m_count - 1 : (m_count + 1) % pw10[ND];
            if (tick && m_mode && m_count == 0) begin
                m_state = M_DONE; m_done = 1; m_lap = 0;
            end else if (fs) begin
                if (m_state == M_IDLE && !(m_mode && m_count == 0)) m_state = M_RUN;
                else if (m_state == M_RUN) m_state = M_PAUSED;
                else if (m_state == M_PAUSED) m_state = M_RUN;
            end else if (fl && (m_state == M_RUN || m_state == M_PAUSED)) begin
                if (!m_lap) m_snap = old;
                m_lap = !m_lap;
            end
        end
        if (m_disp() != prev) exp_q.push_back(to_bcd(m_disp()));
        m_edges++;
        m_idx = (m_edges / SDIV) % ND;
        m_sd = (BLANK && m_idx > 0 && prev / pw10[m_idx] == 0) ? 4'hF : 4'((prev / pw10[m_idx]) % 10);
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge CLOCK_50 or negedge RESET_N);
            if (!RESET_N) m_reset();
            else m_step();
        end
    end

    // Monitor: pops an expected value whenever the displayed value changes
    initial begin
        logic [15:0] last = '0;
        forever begin
            @(negedge CLOCK_50);
            if (!RESET_N) begin
                chk("reset_digits", digits_out, 0);
                chk("reset_scan_pos", scan_pos, 1);
                chk("reset_scan_digit", scan_digit, 0);
                chk("reset_flags", {running, lap_active, done}, 0);
                last = '0;
            end else begin
                if (digits_out !== last) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        if (errors <= 40) $display("FAIL display: got %0h, expected no change from %0h at %0t", digits_out, last, $time);
                    end else chk("display", digits_out, exp_q.pop_front());
                    last = digits_out;
                end
                chk("running", running, m_state == M_RUN);
                chk("lap_active", lap_active, m_lap);
                chk("done", done, m_done);
                chk("scan_pos", scan_pos, 4'b1 << m_idx);
                chk("scan_digit", scan_digit, m_sd);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic press(input bit s, input bit c, input bit l, input int hold);
        @(negedge CLOCK_50);
        if (s) KEY_START_N = 1'b0;
        if (c) KEY_CLEAR_N = 1'b0;
        if (l) KEY_LAP_N = 1'b0;
        cycles(hold);
        KEY_START_N = 1'b1; KEY_CLEAR_N = 1'b1; KEY_LAP_N = 1'b1;
    endtask

    task automatic wait_digits(input logic [15:0] v, input int bound, input string name);
        int k = 0;
        while (digits_out !== v && k < bound) begin
            @(negedge CLOCK_50);
            k++;
        end
        chk(name, digits_out, v);
    endtask

    initial begin
        logic [3:0] seen[4];
        logic [7:0] wlast, wexp;
        int wraps;
        cycles(3);
        RESET_N = 1'b1;
        cycles(2);

        // Stopwatch counts 12 ticks in 125 clocks after the START release
        MODE_DOWN = 1'b0;
        press(0, 1, 0, 2); cycles(4);
        press(1, 0, 0, 2); cycles(125);
        chk("t1_digits", digits_out, 16'h0012);
        chk("t1_running", running, 1);

        // Lap freeze at 5 while the count runs on to 8
        press(0, 1, 0, 2); cycles(4);
        press(1, 0, 0, 2);
        wait_digits(16'h0005, 100, "t4_reach5");
        press(0, 0, 1, 1); cycles(30);
        chk("t4_frozen", digits_out, 16'h0005);
        chk("t4_lap_on", lap_active, 1);
        press(0, 0, 1, 1); cycles(4);
        chk("t4_live", digits_out, 16'h0008);
        chk("t4_lap_off", lap_active, 0);

        // Countdown 3 -> 0 then DONE, START ignored
        MODE_DOWN = 1'b1; PRESET = 16'h0003;
        press(0, 1, 0, 2); cycles(4);
        chk("t2_loaded", digits_out, 16'h0003);
        press(1, 0, 0, 2);
        wait_digits(16'h0000, 60, "t2_zero");
        chk("t2_done", done, 1);
        chk("t2_running", running, 0);
        press(1, 0, 0, 2); cycles(5);
        chk("t2_start_ignored", running, 0);
        chk("t2_done_sticky", done, 1);

        // CLEAR wins over a coincident START; preset nibble clamp
        MODE_DOWN = 1'b0;
        press(0, 1, 0, 2); cycles(4);
        press(1, 0, 0, 2); cycles(25);
        press(1, 1, 0, 2); cycles(5);
        chk("t5_running", running, 0);
        chk("t5_cleared", digits_out, 16'h0000);
        MODE_DOWN = 1'b1; PRESET = 16'h00A1;
        press(0, 1, 0, 2); cycles(4);
        chk("t5_clamp", digits_out, 16'h0091);

        // Scan contents for 0x0040
        PRESET = 16'h0040;
        press(0, 1, 0, 2); cycles(4);
        for (int k = 0; k < 8; k++) begin
            @(negedge CLOCK_50);
            for (int p = 0; p < 4; p++) if (scan_pos[p]) seen[p] = scan_digit;
        end
        chk("t6_pos0", seen[0], 4'h0);
        chk("t6_pos1", seen[1], 4'h4);
        chk("t6_pos2", seen[2], BLANK ? 4'hF : 4'h0);
        chk("t6_pos3", seen[3], BLANK ? 4'hF : 4'h0);

        // Randomized key traffic against the model, with one asynchronous reset
        for (int it = 0; it < 300; it++) begin
            int r = $urandom_range(0, 9);
            if (it == 150) begin
                @(posedge CLOCK_50);
                #2 RESET_N = 1'b0;
                #1;
                chk("async_rst_digits", digits_out, 0);
                chk("async_rst_running", running, 0);
                cycles(2);
                RESET_N = 1'b1;
            end
            if (r < 2) begin
                MODE_DOWN = 1'($urandom_range(0, 1));
                PRESET = {4'($urandom_range(0, 15)) & {4{it[0]}}, 4'h0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
                press(0, 1, 0, $urandom_range(1, 3));
            end else if (r < 6) press(1, 0, 0, $urandom_range(1, 3));
            else if (r < 8) press(0, 0, 1, $urandom_range(1, 3));
            else press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 3));
            cycles($urandom_range(0, 40));
        end

        // 2-digit stopwatch must step 99 -> 00 and keep counting without done
        @(negedge CLOCK_50) W_CLEAR_N = 1'b0;
        cycles(2); W_CLEAR_N = 1'b1;
        cycles(4); W_START_N = 1'b0;
        cycles(2); W_START_N = 1'b1;
        wlast = w_digits;
        wraps = 0;
        for (int k = 0; k < 450 && wraps == 0; k++) begin
            @(negedge CLOCK_50);
            if (w_digits !== wlast) begin
                wexp = 8'(((wlast[7:4] * 10 + wlast[3:0] + 1) % 100) / 10) << 4 | 8'(((wlast[3:0] + 1) % 10));
                chk("wrap_step", w_digits, wexp);
                chk("wrap_done", w_done, 0);
                if (w_digits == 8'h00) wraps++;
                wlast = w_digits;
            end
        end
        chk("wrap_seen", wraps, 1);
        cycles(6);
        chk("wrap_continues", w_digits != 8'h00, 1);

        cycles(3);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
